// File: rtl/game_status_rgb_driver.sv
// rtl/game_status_rgb_driver.sv - two RGB status LEDs with blink-on-entry FSMs; optional PWM via GAME_STATUS_PWM_EN
module game_status_rgb_driver #(
  parameter int TICK_DIV         = 36000,
  parameter int BLINK_HALF_TICKS = 250,
  parameter int BLINK_TOGGLES    = 6,
  parameter int PWM_DUTY         = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] game1_state,
  input  logic [1:0] game2_state,
  output logic [2:0] led16,
  output logic [2:0] led17
);

  localparam int TW  = $clog2(TICK_DIV);
  localparam int HW  = $clog2(BLINK_HALF_TICKS + 1);
  localparam int TGW = $clog2(BLINK_TOGGLES + 1);

  typedef enum logic [2:0] {
    S_PLAY, S_WIN_BLINK, S_WIN_HOLD, S_LOSE_BLINK, S_LOSE_HOLD, S_FAULT
  } state_t;

  if (TICK_DIV < 2 || BLINK_HALF_TICKS < 1 || BLINK_TOGGLES < 1 ||
      PWM_DUTY < 0 || PWM_DUTY > 256) begin : g_param_check
    $error("game_status_rgb_driver: parameter out of range");
  end

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          pwm_on;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // Free-running animation prescaler shared by both LEDs; never realigned to state changes
  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

`ifdef GAME_STATUS_PWM_EN
  logic [7:0] pwm_cnt;

  // Shared 8-bit PWM ramp, wraps 255 -> 0
  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 8'd1;
  end

  // 9-bit compare so PWM_DUTY = 256 means always on
  assign pwm_on = ({1'b0, pwm_cnt} < 9'(PWM_DUTY));
`else
  assign pwm_on = 1'b1;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_led
    logic [1:0]     din;
    logic [1:0]     in_q;
    logic [1:0]     cur_code, cur_d;
    state_t         state_q, state_d;
    logic [HW-1:0]  half_q, half_d;
    logic [TGW-1:0] tog_q, tog_d;
    logic           phase_q, phase_d;
    logic [2:0]     colour;
    logic [2:0]     led_r;

    assign din = (g == 0) ? game1_state : game2_state;

    // Input sample plus FSM state and blink counters
    always_ff @(posedge clk) begin
      if (rst) begin
        in_q     <= 2'b00;
        cur_code <= 2'b00;
        state_q  <= S_PLAY;
        half_q   <= '0;
        tog_q    <= '0;
        phase_q  <= 1'b1;
      end else begin
        in_q     <= din;
        cur_code <= cur_d;
        state_q  <= state_d;
        half_q   <= half_d;
        tog_q    <= tog_d;
        phase_q  <= phase_d;
      end
    end

    // Next state: a code change restarts the animation and beats any coincident tick
    always_comb begin
      cur_d   = cur_code;
      state_d = state_q;
      half_d  = half_q;
      tog_d   = tog_q;
      phase_d = phase_q;
      if (in_q != cur_code) begin
        cur_d   = in_q;
        half_d  = '0;
        tog_d   = '0;
        phase_d = 1'b1;
        case (in_q)
          2'b10:   state_d = S_WIN_BLINK;
          2'b01:   state_d = S_LOSE_BLINK;
          2'b11:   state_d = S_FAULT;
          default: state_d = S_PLAY;
        endcase
      end else if (tick && (state_q == S_WIN_BLINK || state_q == S_LOSE_BLINK)) begin
        if (half_q == HW'(BLINK_HALF_TICKS - 1)) begin
          half_d = '0;
          tog_d  = tog_q + 1'b1;
          if (tog_q == TGW'(BLINK_TOGGLES - 1)) begin
            // Last toggle lands in HOLD with the LED lit
            phase_d = 1'b1;
            if (state_q == S_WIN_BLINK) state_d = S_WIN_HOLD;
            else                        state_d = S_LOSE_HOLD;
          end else begin
            phase_d = ~phase_q;
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end
    end

    // Colour of the current state, {R,G,B}
    always_comb begin
      colour = 3'b001;
      case (state_q)
        S_WIN_BLINK, S_WIN_HOLD:   colour = 3'b010;
        S_LOSE_BLINK, S_LOSE_HOLD: colour = 3'b100;
        S_FAULT:                   colour = 3'b101;
        default:                   colour = 3'b001;
      endcase
    end

    // Registered pad drive: colour gated by blink phase and PWM
    always_ff @(posedge clk) begin
      if (rst) led_r <= 3'b000;
      else     led_r <= colour & {3{phase_q}} & {3{pwm_on}};
    end
  end

  assign led16 = g_led[0].led_r;
  assign led17 = g_led[1].led_r;

endmodule

// File: tb/tb_game_status_rgb_driver.sv
// tb/tb_game_status_rgb_driver.sv - scoreboard bench for game_status_rgb_driver (three PWM duties)
module tb_game_status_rgb_driver;
  localparam int TD  = 4;
  localparam int BHT = 2;
  localparam int BT  = 4;
`ifdef GAME_STATUS_PWM_EN
  localparam bit PWM_EN_M = 1'b1;
`else
  localparam bit PWM_EN_M = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] g1 = 2'b00;
  logic [1:0] g2 = 2'b00;
  logic [2:0] a16, a17, b16, b17, c16, c17;

  int errors = 0;
  int checks = 0;

  logic [17:0] exp_q[$];

  // Reference state: registered inputs, active code, ticks counted since entry
  int unsigned m_j = 0;
  logic [1:0]  m_inq[2];
  logic [1:0]  m_code[2];
  int          m_ticks[2];

  always #5 clk = ~clk;

  game_status_rgb_driver #(.TICK_DIV(TD), .BLINK_HALF_TICKS(BHT), .BLINK_TOGGLES(BT), .PWM_DUTY(256)) dut_a (
    .clk(clk), .rst(rst), .game1_state(g1), .game2_state(g2), .led16(a16), .led17(a17));
  game_status_rgb_driver #(.TICK_DIV(TD), .BLINK_HALF_TICKS(BHT), .BLINK_TOGGLES(BT), .PWM_DUTY(64)) dut_b (
    .clk(clk), .rst(rst), .game1_state(g1), .game2_state(g2), .led16(b16), .led17(b17));
  game_status_rgb_driver #(.TICK_DIV(TD), .BLINK_HALF_TICKS(BHT), .BLINK_TOGGLES(BT), .PWM_DUTY(0)) dut_c (
    .clk(clk), .rst(rst), .game1_state(g1), .game2_state(g2), .led16(c16), .led17(c17));

  function automatic logic [2:0] colour_of(input logic [1:0] c);
    case (c)
      2'b10:   return 3'b010;
      2'b01:   return 3'b100;
      2'b11:   return 3'b101;
      default: return 3'b001;
    endcase
  endfunction

  // Blink phase: half-period index k = ticks/BHT; even k lit, k >= BT means HOLD (lit)
  function automatic bit lit(input logic [1:0] c, input int t);
    int k;
    if (c == 2'b10 || c == 2'b01) begin
      k = t / BHT;
      return (k >= BT) || (k % 2 == 0);
    end
    return 1'b1;
  endfunction

  function automatic bit pwm_m(input int unsigned j, input int duty);
    if (!PWM_EN_M) return 1'b1;
    return int'(j % 256) < duty;
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Reference model: predicts each edge's outputs and queues them
  always @(posedge clk) begin
    logic [2:0] base0, base1;
    bit         tk;
    if (rst) begin
      exp_q.push_back(18'd0);
      m_j = 0;
      for (int i = 0; i < 2; i++) begin
        m_inq[i] = 2'b00; m_code[i] = 2'b00; m_ticks[i] = 0;
      end
    end else begin
      tk    = (m_j % TD) == TD - 1;
      base0 = colour_of(m_code[0]) & {3{lit(m_code[0], m_ticks[0])}};
      base1 = colour_of(m_code[1]) & {3{lit(m_code[1], m_ticks[1])}};
      exp_q.push_back({base0 & {3{pwm_m(m_j, 256)}}, base1 & {3{pwm_m(m_j, 256)}},
                       base0 & {3{pwm_m(m_j, 64)}},  base1 & {3{pwm_m(m_j, 64)}},
                       base0 & {3{pwm_m(m_j, 0)}},   base1 & {3{pwm_m(m_j, 0)}}});
      for (int i = 0; i < 2; i++) begin
        if (m_inq[i] != m_code[i]) begin
          m_code[i]  = m_inq[i];
          m_ticks[i] = 0;
        end else if (tk && (m_code[i] == 2'b10 || m_code[i] == 2'b01) && m_ticks[i] < BHT * BT) begin
          m_ticks[i]++;
        end
      end
      m_inq[0] = g1;
      m_inq[1] = g2;
      m_j++;
    end
  end

  // Monitor: compare DUT outputs against queued predictions away from the active edge
  always @(negedge clk) begin
    logic [17:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("led16_duty256", a16, e[17:15]);
      check("led17_duty256", a17, e[14:12]);
      check("led16_duty64",  b16, e[11:9]);
      check("led17_duty64",  b17, e[8:6]);
      check("led16_duty0",   c16, e[5:3]);
      check("led17_duty0",   c17, e[2:0]);
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a code change whose FSM entry edge lands at tick-counter phase off
  task automatic aligned_change(input logic [1:0] code, input int off);
    int guard = 0;
    while (((m_j + 1) % TD) != off && guard < 10) begin
      hold(1);
      guard++;
    end
    g1 = code;
  endtask

  initial begin
    rst = 1'b1; g1 = 2'b10; g2 = 2'b00;
    hold(3);
    rst = 1'b0; g1 = 2'b00;
    hold(20);
    // WIN entry animation then steady hold
    g1 = 2'b10;
    hold(80);
    // LOSE on LED17, switched to FAULT during the first off-phase
    g2 = 2'b01;
    hold(12);
    g2 = 2'b11;
    hold(100);
    // Code changes coincident with every tick phase, including the tick edge itself
    for (int off = 0; off < TD; off++) begin
      aligned_change(2'b10, off);
      hold(60);
      aligned_change(2'b01, off);
      hold(60);
    end
    // Long holds to cover full PWM periods
    g1 = 2'b10; g2 = 2'b01;
    hold(600);
    // One-cycle glitch restarts the animation
    g1 = 2'b00;
    hold(1);
    g1 = 2'b10;
    hold(60);
    // Reset in the middle of an animation
    g1 = 2'b01;
    hold(10);
    rst = 1'b1;
    hold(2);
    rst = 1'b0;
    hold(40);
    // Randomised codes, hold lengths and occasional resets
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        hold($urandom_range(1, 3));
        rst = 1'b0;
      end
      if ($urandom_range(0, 3) != 0) g1 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) g2 = 2'($urandom_range(0, 3));
      hold($urandom_range(1, 60));
    end
    hold(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
